// File: rtl/micro_sequencer_axi_writer_if.sv
// AXI4-Lite write-only bus bundle between the micro sequencer writer and
// the PL interconnect.
//   master modport : drives AW/W payload and VALIDs, BREADY; samples READYs, B.
//   slave modport  : the mirror image, for interconnect models or peripherals.
interface micro_sequencer_axi_writer_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic [2:0]              M_AXI_AWPROT;
  logic                    M_AXI_AWVALID;
  logic                    M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                    M_AXI_WVALID;
  logic                    M_AXI_WREADY;
  logic [1:0]              M_AXI_BRESP;
  logic                    M_AXI_BVALID;
  logic                    M_AXI_BREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY
  );
endinterface

// File: rtl/micro_sequencer_axi_writer.sv
// AXI4-Lite single-word write master serving the micro sequencer.
// Each sequencer request is offset into the PL peripheral window and issued
// on AW/W; the B response sets write_failed. One request can wait in a
// buffer while another is in flight; further requests are dropped and
// counted. A timeout abandons a transaction whose B never arrives.
// Ports:
//   M_AXI_ACLK, M_AXI_ARESET : clock, asynchronous active-high reset
//   req_wdata/waddr/wstrb/write : request bus from the sequencer
//   write_busy   : transaction in flight or buffered
//   write_failed : result of the last completed (or aborted) transaction
//   drop_count   : saturating count of requests lost to a full buffer
//   m_axi        : AXI4-Lite write channels (master modport)
module micro_sequencer_axi_writer #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH  = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH  = 32,
  parameter logic [31:0] C_M_AXI_ADDR_OFFSET = 32'h4000_0000,
  parameter int unsigned TIMEOUT_CYCLES      = 1023
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic [31:0]                   req_wdata,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] req_waddr,
  input  logic [3:0]                    req_wstrb,
  input  logic                          req_write,
  output logic                          write_busy,
  output logic                          write_failed,
  output logic [7:0]                    drop_count,
  micro_sequencer_axi_writer_if.master  m_axi
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_WAIT_B = 2'd2;

  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_OFFSET =
    C_M_AXI_ADDR_WIDTH'(C_M_AXI_ADDR_OFFSET);

  logic [1:0]                    state, state_n;
  logic [31:0]                   tmr;

  // Buffered request; the address is stored already offset.
  logic                          buf_valid, buf_valid_n;
  logic [C_M_AXI_ADDR_WIDTH-1:0] buf_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0] buf_wdata;
  logic [3:0]                    buf_wstrb;

  logic aw_left, w_left, b_hs, timed_out, finish;
  logic load_req, load_buf, buf_take, req_drop, issue_entry;

  always_comb begin
    aw_left   = m_axi.M_AXI_AWVALID & ~m_axi.M_AXI_AWREADY;
    w_left    = m_axi.M_AXI_WVALID  & ~m_axi.M_AXI_WREADY;
    b_hs      = (state == S_WAIT_B) & m_axi.M_AXI_BVALID & m_axi.M_AXI_BREADY;
    // A B handshake on the timeout cycle still counts as a real completion.
    timed_out = (TIMEOUT_CYCLES != 0) && (state != S_IDLE) &&
                (tmr == TIMEOUT_CYCLES) && !b_hs;
    finish    = b_hs | timed_out;

    buf_take  = req_write && !buf_valid && (state != S_IDLE);
    req_drop  = req_write && buf_valid;

    state_n  = state;
    load_req = 1'b0;
    load_buf = 1'b0;
    case (state)
      S_IDLE: begin
        if (buf_valid) begin
          load_buf = 1'b1;
          state_n  = S_ISSUE;
        end else if (req_write) begin
          load_req = 1'b1;
          state_n  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (timed_out)              state_n = S_IDLE;
        else if (!aw_left && !w_left) state_n = S_WAIT_B;
      end
      S_WAIT_B: begin
        if (finish) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // A full buffer at completion is issued straight away instead of idling.
    if (finish && buf_valid) begin
      load_buf = 1'b1;
      state_n  = S_ISSUE;
    end

    issue_entry = load_req | load_buf;

    buf_valid_n = buf_valid;
    if (load_buf) buf_valid_n = 1'b0;
    if (buf_take) buf_valid_n = 1'b1;
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state                <= S_IDLE;
      tmr                  <= '0;
      buf_valid            <= 1'b0;
      buf_addr             <= '0;
      buf_wdata            <= '0;
      buf_wstrb            <= '0;
      m_axi.M_AXI_AWADDR   <= '0;
      m_axi.M_AXI_AWVALID  <= 1'b0;
      m_axi.M_AXI_WDATA    <= '0;
      m_axi.M_AXI_WSTRB    <= '0;
      m_axi.M_AXI_WVALID   <= 1'b0;
      m_axi.M_AXI_BREADY   <= 1'b0;
      write_busy           <= 1'b0;
      write_failed         <= 1'b0;
      drop_count           <= '0;
    end else begin
      state     <= state_n;
      buf_valid <= buf_valid_n;

      if (buf_take) begin
        buf_addr  <= req_waddr + ADDR_OFFSET;
        buf_wdata <= req_wdata;
        buf_wstrb <= req_wstrb;
      end

      if (load_req) begin
        m_axi.M_AXI_AWADDR <= req_waddr + ADDR_OFFSET;
        m_axi.M_AXI_WDATA  <= req_wdata;
        m_axi.M_AXI_WSTRB  <= req_wstrb;
      end else if (load_buf) begin
        m_axi.M_AXI_AWADDR <= buf_addr;
        m_axi.M_AXI_WDATA  <= buf_wdata;
        m_axi.M_AXI_WSTRB  <= buf_wstrb;
      end

      // AW and W retire independently; the timeout pulls both down.
      if (issue_entry) begin
        m_axi.M_AXI_AWVALID <= 1'b1;
        m_axi.M_AXI_WVALID  <= 1'b1;
      end else if (timed_out) begin
        m_axi.M_AXI_AWVALID <= 1'b0;
        m_axi.M_AXI_WVALID  <= 1'b0;
      end else begin
        m_axi.M_AXI_AWVALID <= aw_left;
        m_axi.M_AXI_WVALID  <= w_left;
      end

      m_axi.M_AXI_BREADY <= (state_n == S_WAIT_B);

      if (issue_entry)          tmr <= '0;
      else if (state != S_IDLE) tmr <= tmr + 32'd1;

      if (b_hs)
        write_failed <= (m_axi.M_AXI_BRESP == 2'b10) || (m_axi.M_AXI_BRESP == 2'b11);
      else if (timed_out)
        write_failed <= 1'b1;

      if (req_drop && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;

      write_busy <= (state_n != S_IDLE) | buf_valid_n;
    end
  end

  assign m_axi.M_AXI_AWPROT = 3'b000;

endmodule

// File: tb/tb_micro_sequencer_axi_writer.sv
module tb_micro_sequencer_axi_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_waddr = '0;
  logic [3:0]  req_wstrb = '0;
  logic        req_write = 1'b0;
  logic        write_busy, write_failed;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  micro_sequencer_axi_writer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  micro_sequencer_axi_writer #(
    .C_M_AXI_ADDR_WIDTH (32),
    .C_M_AXI_DATA_WIDTH (32),
    .C_M_AXI_ADDR_OFFSET(32'h4000_0000),
    .TIMEOUT_CYCLES     (16)
  ) dut (
    .M_AXI_ACLK  (clk),
    .M_AXI_ARESET(rst),
    .req_wdata   (req_wdata),
    .req_waddr   (req_waddr),
    .req_wstrb   (req_wstrb),
    .req_write   (req_write),
    .write_busy  (write_busy),
    .write_failed(write_failed),
    .drop_count  (drop_count),
    .m_axi       (axi.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_waddr = a;
    req_wdata = d;
    req_wstrb = s;
    req_write = 1'b1;
  endtask

  task automatic slave(input logic awr, input logic wr, input logic bv, input logic [1:0] br);
    axi.M_AXI_AWREADY = awr;
    axi.M_AXI_WREADY  = wr;
    axi.M_AXI_BVALID  = bv;
    axi.M_AXI_BRESP   = br;
  endtask

  initial begin
    slave(1'b0, 1'b0, 1'b0, 2'b00);

    // Reset values
    tick();
    tick();
    check("rst_awvalid", 32'(axi.M_AXI_AWVALID), 32'd0);
    check("rst_wvalid",  32'(axi.M_AXI_WVALID),  32'd0);
    check("rst_bready",  32'(axi.M_AXI_BREADY),  32'd0);
    check("rst_awaddr",  axi.M_AXI_AWADDR,       32'd0);
    check("rst_busy",    32'(write_busy),        32'd0);
    check("rst_failed",  32'(write_failed),      32'd0);
    check("rst_drop",    32'(drop_count),        32'd0);
    rst = 1'b0;
    tick();

    // Always-ready slave, minimum latency
    slave(1'b1, 1'b1, 1'b1, 2'b00);
    request(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    tick();
    req_write = 1'b0;
    check("t1_awvalid", 32'(axi.M_AXI_AWVALID), 32'd1);
    check("t1_wvalid",  32'(axi.M_AXI_WVALID),  32'd1);
    check("t1_awaddr",  axi.M_AXI_AWADDR,       32'h4000_0010);
    check("t1_wdata",   axi.M_AXI_WDATA,        32'hDEAD_BEEF);
    check("t1_wstrb",   32'(axi.M_AXI_WSTRB),   32'hF);
    check("t1_awprot",  32'(axi.M_AXI_AWPROT),  32'd0);
    check("t1_busy_c1", 32'(write_busy),        32'd1);
    tick();
    check("t1_bready_c2",  32'(axi.M_AXI_BREADY),  32'd1);
    check("t1_awvalid_c2", 32'(axi.M_AXI_AWVALID), 32'd0);
    check("t1_wvalid_c2",  32'(axi.M_AXI_WVALID),  32'd0);
    tick();
    check("t1_bready_c3", 32'(axi.M_AXI_BREADY), 32'd0);
    check("t1_busy_c3",   32'(write_busy),       32'd0);
    check("t1_failed",    32'(write_failed),     32'd0);

    // AWREADY late, WREADY immediate, SLVERR response
    slave(1'b0, 1'b1, 1'b0, 2'b10);
    request(32'h0000_0024, 32'h1234_5678, 4'h3);
    tick();
    req_write = 1'b0;
    check("t2_awvalid_c1", 32'(axi.M_AXI_AWVALID), 32'd1);
    check("t2_wvalid_c1",  32'(axi.M_AXI_WVALID),  32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_wvalid_low",  32'(axi.M_AXI_WVALID),  32'd0);
      check("t2_awvalid_hold", 32'(axi.M_AXI_AWVALID), 32'd1);
      check("t2_awaddr_hold", axi.M_AXI_AWADDR,       32'h4000_0024);
    end
    axi.M_AXI_AWREADY = 1'b1;
    tick();
    check("t2_awvalid_done", 32'(axi.M_AXI_AWVALID), 32'd0);
    check("t2_bready",       32'(axi.M_AXI_BREADY),  32'd1);
    slave(1'b0, 1'b1, 1'b1, 2'b10);
    tick();
    axi.M_AXI_BVALID = 1'b0;
    check("t2_failed_slverr", 32'(write_failed),       32'd1);
    check("t2_bready_low",    32'(axi.M_AXI_BREADY),   32'd0);
    check("t2_busy_low",      32'(write_busy),         32'd0);
    tick();
    check("t2_failed_holds",  32'(write_failed),       32'd1);
    slave(1'b1, 1'b1, 1'b1, 2'b00);
    request(32'h0000_0028, 32'h0BAD_F00D, 4'hF);
    tick();
    req_write = 1'b0;
    tick();
    tick();
    check("t2_failed_okay", 32'(write_failed), 32'd0);

    // Buffer and drop under a stalled slave
    slave(1'b0, 1'b0, 1'b0, 2'b00);
    request(32'h0000_0100, 32'h0000_000A, 4'hF);
    tick();
    request(32'h0000_0200, 32'h0000_000B, 4'hF);
    tick();
    request(32'h0000_0300, 32'h0000_000C, 4'hF);
    tick();
    req_write = 1'b0;
    check("t3_drop",     32'(drop_count),  32'd1);
    check("t3_busy",     32'(write_busy),  32'd1);
    check("t3_awaddr_a", axi.M_AXI_AWADDR, 32'h4000_0100);
    slave(1'b1, 1'b1, 1'b0, 2'b00);
    tick();
    check("t3_bready_a", 32'(axi.M_AXI_BREADY), 32'd1);
    slave(1'b1, 1'b1, 1'b1, 2'b00);
    tick();
    check("t3_awvalid_b", 32'(axi.M_AXI_AWVALID), 32'd1);
    check("t3_awaddr_b",  axi.M_AXI_AWADDR,       32'h4000_0200);
    check("t3_wdata_b",   axi.M_AXI_WDATA,        32'h0000_000B);
    check("t3_busy_mid",  32'(write_busy),        32'd1);
    tick();
    check("t3_busy_waitb", 32'(write_busy), 32'd1);
    tick();
    check("t3_busy_end", 32'(write_busy), 32'd0);
    check("t3_drop_end", 32'(drop_count), 32'd1);

    // Drop counter saturation with a hung slave (timeouts keep draining)
    slave(1'b0, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 300; i++) begin
      request(32'h1000 + 32'(i * 4), 32'(i), 4'hF);
      tick();
    end
    req_write = 1'b0;
    check("t4_drop_sat", 32'(drop_count), 32'd255);
    for (int i = 0; i < 100 && write_busy; i++) tick();
    check("t4_drained", 32'(write_busy), 32'd0);
    check("t4_drop_still_sat", 32'(drop_count), 32'd255);

    // Timeout: slave accepts AW/W but never responds
    slave(1'b1, 1'b1, 1'b1, 2'b00);
    request(32'h0000_0040, 32'h5555_AAAA, 4'hF);
    tick();
    req_write = 1'b0;
    tick();
    tick();
    check("t5_pre_failed", 32'(write_failed), 32'd0);
    slave(1'b1, 1'b1, 1'b0, 2'b00);
    request(32'h0000_0044, 32'h6666_BBBB, 4'hF);
    tick();
    req_write = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    check("t5_busy_at16",   32'(write_busy),       32'd1);
    check("t5_bready_at16", 32'(axi.M_AXI_BREADY), 32'd1);
    check("t5_failed_at16", 32'(write_failed),     32'd0);
    tick();
    check("t5_busy_after",   32'(write_busy),       32'd0);
    check("t5_failed_after", 32'(write_failed),     32'd1);
    check("t5_bready_after", 32'(axi.M_AXI_BREADY), 32'd0);

    // Reset during WAIT_B
    request(32'h0000_0050, 32'h7777_CCCC, 4'hF);
    tick();
    req_write = 1'b0;
    tick();
    check("t6_bready_pre", 32'(axi.M_AXI_BREADY), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_bready",  32'(axi.M_AXI_BREADY),  32'd0);
    check("t6_awvalid", 32'(axi.M_AXI_AWVALID), 32'd0);
    check("t6_awaddr",  axi.M_AXI_AWADDR,       32'd0);
    check("t6_wdata",   axi.M_AXI_WDATA,        32'd0);
    check("t6_busy",    32'(write_busy),        32'd0);
    check("t6_failed",  32'(write_failed),      32'd0);
    check("t6_drop",    32'(drop_count),        32'd0);
    tick();
    rst = 1'b0;
    tick();
    slave(1'b1, 1'b1, 1'b1, 2'b00);
    request(32'h0000_0060, 32'h8888_DDDD, 4'hF);
    tick();
    req_write = 1'b0;
    check("t6_post_awaddr", axi.M_AXI_AWADDR, 32'h4000_0060);
    tick();
    tick();
    check("t6_post_busy",   32'(write_busy),   32'd0);
    check("t6_post_failed", 32'(write_failed), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
